// File: rtl/id_operand_stage.sv
// Decode-side operand stage: holds one instruction, reads its source registers and
// resolves each operand against youngest-first forwarding sources with load-use interlock.
module id_operand_stage #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int NUM_FWD   = 3,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_allow_in,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [NUM_SRC*REG_AW-1:0] in_src_addr,
  input  logic [NUM_SRC-1:0]        in_src_used,
  output logic                      out_valid,
  input  logic                      out_allow_in,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [NUM_SRC*XLEN-1:0]   out_src_value,
  output logic [NUM_SRC*REG_AW-1:0] rf_raddr,
  input  logic [NUM_SRC*XLEN-1:0]   rf_rdata,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_value,
  input  logic [NUM_FWD-1:0]        fwd_ready,
  input  logic                      flush,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic                      valid_p0;
  logic [PAYLOAD_W-1:0]      payload_p0;
  logic [NUM_SRC*REG_AW-1:0] src_addr_p0;
  logic [NUM_SRC-1:0]        src_used_p0;

  logic [NUM_SRC-1:0] hit;
  logic [NUM_SRC-1:0] hit_rdy;
  logic [NUM_SRC-1:0] hazard;
  logic               ready_go;
  logic               load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Walk sources oldest to youngest so the youngest match is the last one written.
  always_comb begin
    out_src_value = '0;
    hit           = '0;
    hit_rdy       = '0;
    hazard        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      out_src_value[i*XLEN +: XLEN] = rf_rdata[i*XLEN +: XLEN];
      for (int k = NUM_FWD-1; k >= 0; k--) begin
        if (valid_p0 && src_used_p0[i] && (src_addr_p0[i*REG_AW +: REG_AW] != '0) &&
            fwd_valid[k] && (fwd_dest[k*REG_AW +: REG_AW] == src_addr_p0[i*REG_AW +: REG_AW])) begin
          hit[i]                        = 1'b1;
          hit_rdy[i]                    = fwd_ready[k];
          out_src_value[i*XLEN +: XLEN] = fwd_value[k*XLEN +: XLEN];
        end
      end
      if (src_addr_p0[i*REG_AW +: REG_AW] == '0)
        out_src_value[i*XLEN +: XLEN] = '0;
      hazard[i] = hit[i] & ~hit_rdy[i];
    end
  end

  assign ready_go    = ~(|hazard);
  assign out_valid   = valid_p0 & ready_go & ~flush;
  assign in_allow_in = ~valid_p0 | (ready_go & out_allow_in) | flush;
  assign load        = in_valid & in_allow_in & ~flush;
  assign out_payload = payload_p0;
  assign rf_raddr    = src_addr_p0;

  // Stage p0: instruction register
  always_ff @(posedge clk) begin
    if (reset)
      valid_p0 <= 1'b0;
    else if (flush)
      valid_p0 <= 1'b0;
    else if (in_allow_in)
      valid_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      payload_p0  <= '0;
      src_addr_p0 <= '0;
      src_used_p0 <= '0;
    end else if (load) begin
      payload_p0  <= in_payload;
      src_addr_p0 <= in_src_addr;
      src_used_p0 <= in_src_used;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (valid_p0 && !ready_go && !flush)
      stall_cnt <= sat_inc(stall_cnt);
  end

endmodule
